// File: rtl/cpu_defs.sv
// Shared CPU definitions: reset vector, fetch state encoding and the canonical NOP.
package cpu_defs;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
   localparam logic [31:0] INST_NOP         = 32'h03400000;

   typedef enum logic [1:0] {
      FS_REQ  = 2'd0,
      FS_WAIT = 2'd1,
      FS_HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, drives the SRAM-like instruction
// bus with one outstanding request, absorbs redirects and hands one instruction to IF.
module fetch_ctrl
   import cpu_defs::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_redirect_valid,
   input  logic [31:0] ex_redirect_pc,
   input  logic        br_redirect_valid,
   input  logic [31:0] br_redirect_pc,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   input  logic        if_allow_in,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
);

   fetch_state_e state, state_n;
   logic [31:0]  pc, pc_n;
   logic [31:0]  req_pc, req_pc_n;
   logic         discard, discard_n;
   logic [31:0]  hold_pc, hold_pc_n;
   logic [31:0]  hold_inst, hold_inst_n;

   logic         redir;
   logic [31:0]  target;

   // Exception/ertn redirect outranks a branch redirect in the same cycle.
   assign redir  = ex_redirect_valid | br_redirect_valid;
   assign target = ex_redirect_valid ? ex_redirect_pc : br_redirect_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FS_REQ;
         pc        <= RESET_PC;
         req_pc    <= '0;
         discard   <= 1'b0;
         hold_pc   <= '0;
         hold_inst <= '0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         req_pc    <= req_pc_n;
         discard   <= discard_n;
         hold_pc   <= hold_pc_n;
         hold_inst <= hold_inst_n;
      end
   end

   always_comb begin
      state_n     = state;
      pc_n        = pc;
      req_pc_n    = req_pc;
      discard_n   = discard;
      hold_pc_n   = hold_pc;
      hold_inst_n = hold_inst;
      case (state)
         FS_REQ: begin
            if (inst_addr_ok) begin
               state_n = FS_WAIT;
               if (redir) begin
                  // Address already accepted: its data must be thrown away on return.
                  discard_n = 1'b1;
                  pc_n      = target;
               end else begin
                  req_pc_n = pc;
                  pc_n     = pc + 32'd4;
               end
            end else if (redir) begin
               pc_n = target;
            end
         end
         FS_WAIT: begin
            if (redir) pc_n = target;
            if (inst_data_ok) begin
               if (!discard && !redir) begin
                  hold_pc_n   = req_pc;
                  hold_inst_n = inst_rdata;
                  state_n     = FS_HOLD;
               end else begin
                  discard_n = 1'b0;
                  state_n   = FS_REQ;
               end
            end else if (redir) begin
               discard_n = 1'b1;
            end
         end
         FS_HOLD: begin
            if (redir) begin
               pc_n    = target;
               state_n = FS_REQ;
            end else if (if_allow_in) begin
               state_n = FS_REQ;
            end
         end
         default: state_n = FS_REQ;
      endcase
   end

   // rst gating keeps the bus quiet while reset is held, even though state reads REQ.
   assign inst_req  = (state == FS_REQ) && !rst;
   assign inst_addr = pc;
   assign if_valid  = (state == FS_HOLD);
   assign if_pc     = hold_pc;
   assign if_inst   = hold_inst;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_fetch_ctrl;
   import cpu_defs::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_redirect_valid = 1'b0;
   logic [31:0] ex_redirect_pc = '0;
   logic        br_redirect_valid = 1'b0;
   logic [31:0] br_redirect_pc = '0;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok = 1'b0;
   logic        inst_data_ok = 1'b0;
   logic [31:0] inst_rdata = '0;
   logic        if_allow_in = 1'b0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   int total = 0;
   int bad   = 0;

   fetch_ctrl #(.RESET_PC(32'h1c000000)) dut (
      .clk(clk), .rst(rst),
      .ex_redirect_valid(ex_redirect_valid), .ex_redirect_pc(ex_redirect_pc),
      .br_redirect_valid(br_redirect_valid), .br_redirect_pc(br_redirect_pc),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .if_allow_in(if_allow_in), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: a fixed scramble of the address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5a3c_0f81;
   endfunction

   // Reference model: bus transaction outstanding / stale / instruction held.
   logic [31:0] m_pc, m_bus_addr, m_hpc, m_hinst;
   bit          m_busy, m_stale, m_held;

   task automatic model_reset();
      m_pc = 32'h1c000000; m_busy = 0; m_stale = 0; m_held = 0;
      m_hpc = '0; m_hinst = '0; m_bus_addr = '0;
   endtask

   // Drive one cycle of inputs, advance the model across the edge, return #1 after it.
   task automatic tick(input bit exv, input logic [31:0] exa, input bit brv,
                       input logic [31:0] bra, input bit aok, input bit dok, input bit allow);
      bit          rd;
      logic [31:0] tgt, rdat;
      rd   = exv | brv;
      tgt  = exv ? exa : bra;
      rdat = m_busy ? mem(m_bus_addr) : $urandom;
      ex_redirect_valid = exv; ex_redirect_pc = exa;
      br_redirect_valid = brv; br_redirect_pc = bra;
      inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rdat; if_allow_in = allow;
      if (m_held) begin
         if (rd) begin m_held = 0; m_pc = tgt; end
         else if (allow) m_held = 0;
      end else if (m_busy) begin
         if (dok) begin
            m_busy = 0;
            if (!m_stale && !rd) begin m_held = 1; m_hpc = m_bus_addr; m_hinst = rdat; end
            m_stale = 0;
         end else if (rd) m_stale = 1;
         if (rd) m_pc = tgt;
      end else if (aok) begin
         m_busy = 1; m_bus_addr = m_pc;
         if (rd) begin m_stale = 1; m_pc = tgt; end
         else m_pc = m_pc + 32'd4;
      end else if (rd) m_pc = tgt;
      @(posedge clk);
      #1;
      ex_redirect_valid = 0; br_redirect_valid = 0;
      inst_addr_ok = 0; inst_data_ok = 0; if_allow_in = 0;
   endtask

   task automatic test_reset();
      model_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", inst_req); end
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
      total++; if (if_pc !== 32'h0 || if_inst !== 32'h0) begin
         bad++; $display("FAIL reset_if got=%h/%h exp=0/0", if_pc, if_inst); end
      rst = 1'b0;
      #1;
      total++; if (inst_req !== 1'b1 || inst_addr !== 32'h1c000000) begin
         bad++; $display("FAIL reset_first_req got=%b/%h exp=1/1c000000", inst_req, inst_addr); end
   endtask

   task automatic test_sequential();
      for (int k = 0; k < 3; k++) begin
         logic [31:0] a;
         a = 32'h1c000000 + 32'(4 * k);
         total++; if (inst_req !== 1'b1 || inst_addr !== a) begin
            bad++; $display("FAIL seq_addr%0d got=%b/%h exp=1/%h", k, inst_req, inst_addr, a); end
         tick(0, 0, 0, 0, 1, 0, 0);
         total++; if (inst_req !== 1'b0 || if_valid !== 1'b0) begin
            bad++; $display("FAIL seq_wait%0d got=%b/%b exp=0/0", k, inst_req, if_valid); end
         tick(0, 0, 0, 0, 0, 1, 0);
         total++; if (if_valid !== 1'b1 || if_pc !== a || if_inst !== mem(a)) begin
            bad++; $display("FAIL seq_deliver%0d got=%b/%h/%h exp=1/%h/%h", k, if_valid, if_pc, if_inst, a, mem(a)); end
         tick(0, 0, 0, 0, 0, 0, 1);
      end
   endtask

   task automatic test_branch_wait();
      tick(0, 0, 0, 0, 1, 0, 0);
      tick(0, 0, 1, 32'h1c000100, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0, 0);
      total++; if (if_valid !== 1'b0 || inst_req !== 1'b0) begin
         bad++; $display("FAIL br_wait_idle got=%b/%b exp=0/0", if_valid, inst_req); end
      tick(0, 0, 0, 0, 0, 1, 0);
      total++; if (if_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h1c000100) begin
         bad++; $display("FAIL br_wait_drop got=%b/%b/%h exp=0/1/1c000100", if_valid, inst_req, inst_addr); end
   endtask

   task automatic test_both_redirect();
      tick(1, 32'h1c008000, 1, 32'h1c000200, 0, 0, 0);
      total++; if (inst_req !== 1'b1 || inst_addr !== 32'h1c008000) begin
         bad++; $display("FAIL ex_priority got=%b/%h exp=1/1c008000", inst_req, inst_addr); end
   endtask

   task automatic test_hold_stall();
      tick(0, 0, 0, 0, 1, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         tick(0, 0, 0, 0, 0, 0, 0);
         total++; if (if_valid !== 1'b1 || inst_req !== 1'b0 || if_pc !== 32'h1c008000 ||
                      if_inst !== mem(32'h1c008000)) begin
            bad++; $display("FAIL hold_stable%0d got=%b/%b/%h/%h exp=1/0/1c008000/%h",
                            i, if_valid, inst_req, if_pc, if_inst, mem(32'h1c008000)); end
      end
      tick(0, 0, 0, 0, 0, 0, 1);
      total++; if (inst_req !== 1'b1 || inst_addr !== 32'h1c008004 || if_valid !== 1'b0) begin
         bad++; $display("FAIL hold_release got=%b/%h/%b exp=1/1c008004/0", inst_req, inst_addr, if_valid); end
   endtask

   task automatic test_hold_redirect();
      tick(0, 0, 0, 0, 1, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 0);
      tick(0, 0, 1, 32'h1c000400, 0, 0, 1);
      total++; if (if_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h1c000400) begin
         bad++; $display("FAIL hold_redirect got=%b/%b/%h exp=0/1/1c000400", if_valid, inst_req, inst_addr); end
   endtask

   task automatic test_redirect_addr_ok();
      tick(0, 0, 1, 32'h1c000300, 1, 0, 0);
      total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL aok_redir_wait got=%b exp=0", inst_req); end
      tick(0, 0, 0, 0, 0, 1, 0);
      total++; if (if_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h1c000300) begin
         bad++; $display("FAIL aok_redir_drop got=%b/%b/%h exp=0/1/1c000300", if_valid, inst_req, inst_addr); end
      tick(0, 0, 0, 0, 1, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 0);
      total++; if (if_valid !== 1'b1 || if_pc !== 32'h1c000300 || if_inst !== mem(32'h1c000300)) begin
         bad++; $display("FAIL aok_redir_target got=%b/%h/%h exp=1/1c000300/%h", if_valid, if_pc, if_inst, mem(32'h1c000300)); end
      tick(0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic test_wrap_and_reset();
      tick(0, 0, 1, 32'hfffffffc, 0, 0, 0);
      tick(0, 0, 0, 0, 1, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 0);
      total++; if (if_valid !== 1'b1 || if_pc !== 32'hfffffffc) begin
         bad++; $display("FAIL wrap_deliver got=%b/%h exp=1/fffffffc", if_valid, if_pc); end
      tick(0, 0, 0, 0, 0, 0, 1);
      total++; if (inst_req !== 1'b1 || inst_addr !== 32'h0) begin
         bad++; $display("FAIL wrap_addr got=%b/%h exp=1/00000000", inst_req, inst_addr); end
      tick(0, 0, 0, 0, 1, 0, 0);
      #2 rst = 1'b1;
      model_reset();
      #1;
      total++; if (inst_req !== 1'b0 || if_valid !== 1'b0) begin
         bad++; $display("FAIL midreset_quiet got=%b/%b exp=0/0", inst_req, if_valid); end
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      total++; if (inst_req !== 1'b1 || inst_addr !== 32'h1c000000 || if_valid !== 1'b0) begin
         bad++; $display("FAIL midreset_req got=%b/%h/%b exp=1/1c000000/0", inst_req, inst_addr, if_valid); end
      // Data for the killed request must not surface after reset.
      tick(0, 0, 0, 0, 1, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 0);
      total++; if (if_valid !== 1'b1 || if_pc !== 32'h1c000000) begin
         bad++; $display("FAIL midreset_refetch got=%b/%h exp=1/1c000000", if_valid, if_pc); end
      tick(0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int i = 0; i < 3000; i++) begin
         bit exv, brv, aok, dok, allow;
         exv   = ($urandom_range(0, 19) == 0);
         brv   = ($urandom_range(0, 9) == 0);
         aok   = ($urandom_range(0, 2) != 0);
         dok   = m_busy ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
         allow = ($urandom_range(0, 2) != 0);
         tick(exv, {$urandom_range(0, 32'hffff), 2'b00} | 32'h1c000000, brv,
              {$urandom_range(0, 32'hffff), 2'b00} | 32'h1d000000, aok, dok, allow);
         total++;
         if (inst_req !== (!m_busy && !m_held) || if_valid !== m_held ||
             (inst_req && inst_addr !== m_pc) ||
             (m_held && (if_pc !== m_hpc || if_inst !== m_hinst))) begin
            bad++;
            if (errs < 10)
               $display("FAIL rand_cycle%0d got req=%b addr=%h v=%b pc=%h inst=%h exp req=%b addr=%h v=%b pc=%h inst=%h",
                        i, inst_req, inst_addr, if_valid, if_pc, if_inst,
                        !m_busy && !m_held, m_pc, m_held, m_hpc, m_hinst);
            errs++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch_wait();
      test_both_redirect();
      test_hold_stall();
      test_hold_redirect();
      test_redirect_addr_ok();
      test_wrap_and_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
